// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the hardwired-zero register index.
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    function automatic logic is_reg_zero(input logic [REG_IDX_W-1:0] idx);
        return (idx == REG_ZERO);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturation-free up/down pending-write counter for one architectural register.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             is_max
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next count: clear dominates, simultaneous inc and dec cancel.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else if (inc && !dec) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (dec && !inc) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_nxt_s;
    assign is_max     = &count_r;

endmodule

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard between issue and writeback; stalls issue on
// RAW hazards, full counters and flush.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 issue_use_rs1,
    input  logic                 issue_use_rs2,
    input  logic                 issue_RegWrite,
    input  logic [REG_IDX_W-1:0] issue_rd,
    output logic                 stall,
    output logic                 issue_fire,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 flush,
    output logic                 busy_any,
    output logic                 wb_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_s     [NREG];
    logic [CNT_W-1:0] cnt_nxt_s [1:NREG-1];
    logic             max_s     [NREG];
    logic [NREG-1:1]  inc_s;
    logic [NREG-1:1]  dec_s;
    logic [NREG-1:0]  busy_s;
    logic             stall_s;
    logic             fire_s;
    logic             wb_to_empty_s;
    logic             busy_any_nxt_s;
    logic             busy_any_r;
    logic             wb_err_r;

    // Register 0 is never counted, so its slot is a constant empty counter.
    assign cnt_s[0] = CNT_ZERO;
    assign max_s[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .CLK       (CLK),
            .RST       (RST),
            .inc       (inc_s[r]),
            .dec       (dec_s[r]),
            .clr       (flush),
            .count     (cnt_s[r]),
            .count_next(cnt_nxt_s[r]),
            .is_max    (max_s[r])
        );
    end

    // Per-register busy view; with bypass a last write retiring now counts as done.
    always_comb begin
        busy_s = {NREG{1'b0}};
        for (int r = 1; r < NREG; r++) begin
            busy_s[r] = (cnt_s[r] != CNT_ZERO) &&
                        !(WB_BYPASS && wb_valid && (wb_rd == REG_IDX_W'(r)) &&
                          (cnt_s[r] == CNT_ONE));
        end
    end

    // Issue hazard check: RAW on used sources, full destination counter, or flush.
    always_comb begin
        stall_s = issue_valid &&
                  ((issue_use_rs1 && busy_s[issue_rs1]) ||
                   (issue_use_rs2 && busy_s[issue_rs2]) ||
                   (issue_RegWrite && !is_reg_zero(issue_rd) && max_s[issue_rd]) ||
                   flush);
        fire_s  = issue_valid && !stall_s;
    end

    // Counter steering; a fired issue is already blocked by flush, the decrement is gated here.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_s[r] = fire_s && issue_RegWrite && (issue_rd == REG_IDX_W'(r));
            dec_s[r] = wb_valid && !flush && (wb_rd == REG_IDX_W'(r)) &&
                       (cnt_s[r] != CNT_ZERO);
        end
        wb_to_empty_s = wb_valid && !flush && !is_reg_zero(wb_rd) &&
                        (cnt_s[wb_rd] == CNT_ZERO);
    end

    // OR-reduce of post-update counts feeding the registered busy_any flag.
    always_comb begin
        busy_any_nxt_s = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            busy_any_nxt_s = busy_any_nxt_s | (cnt_nxt_s[r] != CNT_ZERO);
        end
    end

    // Status flags; wb_err is sticky until reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_any_r <= 1'b0;
            wb_err_r   <= 1'b0;
        end else begin
            busy_any_r <= busy_any_nxt_s;
            wb_err_r   <= wb_err_r | wb_to_empty_s;
        end
    end

    assign stall      = stall_s;
    assign issue_fire = fire_s;
    assign busy_any   = busy_any_r;
    assign wb_err     = wb_err_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: runs a no-bypass and a bypass instance in lockstep
// against hand-derived vectors, a reset sequence and a reference model.
module tb_regfile_scoreboard;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       issue_valid, issue_use_rs1, issue_use_rs2, issue_RegWrite;
    logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic       wb_valid, flush;
    logic       stall0, fire0, busy_any0, wb_err0;
    logic       stall1, fire1, busy_any1, wb_err1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       iv;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       rw;
        logic [4:0] rd;
        logic       wv;
        logic [4:0] wrd;
        logic       fl;
        logic       es0;
        logic       es1;
    } vec_t;

    typedef struct {
        bit ba0;
        bit er0;
        bit ba1;
        bit er1;
    } reg_exp_t;

    reg_exp_t exp_q[$];
    int       m_cnt[2][32];
    bit       m_err[2];
    vec_t     tab[29];

    regfile_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b0)) dut (
        .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_RegWrite(issue_RegWrite), .issue_rd(issue_rd), .stall(stall0),
        .issue_fire(fire0), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_any(busy_any0), .wb_err(wb_err0)
    );

    regfile_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1)) dut_byp (
        .CLK(CLK), .RST(RST), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_RegWrite(issue_RegWrite), .issue_rd(issue_rd), .stall(stall1),
        .issue_fire(fire1), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_any(busy_any1), .wb_err(wb_err1)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic iv, input int rs1, input logic u1, input int rs2,
                                input logic u2, input logic rw, input int rd, input logic wv,
                                input int wrd, input logic fl, input logic es0, input logic es1);
        vec_t v;
        v.iv = iv;  v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
        v.rw = rw;  v.rd = 5'(rd);   v.wv = wv; v.wrd = 5'(wrd); v.fl = fl;
        v.es0 = es0; v.es1 = es1;
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit m_busy(input int b, input vec_t v, input int r);
        if (r == 0 || m_cnt[b][r] == 0) return 1'b0;
        if (b == 1 && v.wv && int'(v.wrd) == r && m_cnt[b][r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall(input int b, input vec_t v);
        bit hz;
        hz = (v.u1 && m_busy(b, v, int'(v.rs1))) || (v.u2 && m_busy(b, v, int'(v.rs2))) ||
             (v.rw && v.rd != 5'd0 && m_cnt[b][v.rd] == 3) || v.fl;
        return v.iv && hz;
    endfunction

    task automatic m_update(input int b, input vec_t v, input bit st);
        bit inc, dec;
        if (v.fl) begin
            for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
        end else begin
            inc = v.iv && !st && v.rw && v.rd != 5'd0;
            dec = v.wv && v.wrd != 5'd0 && m_cnt[b][v.wrd] != 0;
            if (v.wv && v.wrd != 5'd0 && m_cnt[b][v.wrd] == 0) m_err[b] = 1'b1;
            if (!(inc && dec && v.rd == v.wrd)) begin
                if (inc) m_cnt[b][v.rd] = m_cnt[b][v.rd] + 1;
                if (dec) m_cnt[b][v.wrd] = m_cnt[b][v.wrd] - 1;
            end
        end
    endtask

    function automatic bit m_any(input int b);
        for (int r = 1; r < 32; r++) if (m_cnt[b][r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 32; r++) m_cnt[b][r] = 0;
            m_err[b] = 1'b0;
        end
    endtask

    task automatic drive_idle();
        issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_use_rs1 = 1'b0;
        issue_use_rs2 = 1'b0; issue_RegWrite = 1'b0; issue_rd = 5'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    endtask

    // One cycle: drive, check combinational outputs, push registered expectations, compare after the edge.
    task automatic apply(input vec_t v, input bit use_tab);
        bit s0, s1;
        reg_exp_t e;
        @(negedge CLK);
        issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs2 = v.rs2; issue_use_rs1 = v.u1;
        issue_use_rs2 = v.u2; issue_RegWrite = v.rw; issue_rd = v.rd;
        wb_valid = v.wv; wb_rd = v.wrd; flush = v.fl;
        #1;
        s0 = use_tab ? v.es0 : m_stall(0, v);
        s1 = use_tab ? v.es1 : m_stall(1, v);
        chk("stall", stall0, s0);
        chk("issue_fire", fire0, v.iv & ~s0);
        chk("stall_byp", stall1, s1);
        chk("issue_fire_byp", fire1, v.iv & ~s1);
        m_update(0, v, s0);
        m_update(1, v, s1);
        e.ba0 = m_any(0); e.er0 = m_err[0]; e.ba1 = m_any(1); e.er1 = m_err[1];
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk("busy_any", busy_any0, e.ba0);
        chk("wb_err", wb_err0, e.er0);
        chk("busy_any_byp", busy_any1, e.ba1);
        chk("wb_err_byp", wb_err1, e.er1);
    endtask

    initial begin
        // iv rs1 u1 rs2 u2 rw rd wv wrd fl | stall(no bypass) stall(bypass)
        tab[0]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        tab[1]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tab[2]  = mk(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 1, 0);
        tab[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[4]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        tab[5]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        tab[6]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        tab[7]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1);
        tab[8]  = mk(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 1, 1);
        tab[9]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        tab[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        tab[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        tab[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        tab[13] = mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        tab[14] = mk(1, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 0);
        tab[15] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        tab[17] = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tab[18] = mk(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tab[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        tab[20] = mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        tab[21] = mk(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
        tab[22] = mk(1, 0, 0, 0, 0, 1, 11, 1, 10, 1, 1, 1);
        tab[23] = mk(1, 10, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
        tab[24] = mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
        tab[25] = mk(1, 1, 1, 12, 1, 0, 0, 0, 0, 0, 1, 1);
        tab[26] = mk(1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0);
        tab[27] = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        tab[28] = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);

        drive_idle();
        m_reset();
        #12;
        chk("reset_busy_any", busy_any0, 1'b0);
        chk("reset_wb_err", wb_err0, 1'b0);
        chk("reset_busy_any_byp", busy_any1, 1'b0);
        chk("reset_stall", stall0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 29; i++) apply(tab[i], 1'b1);

        // Reset mid-run while cnt[5]=2, cnt[12]=1 and wb_err set.
        @(negedge CLK);
        drive_idle();
        RST = 1'b1;
        #2;
        chk("midrst_busy_any", busy_any0, 1'b0);
        chk("midrst_wb_err", wb_err0, 1'b0);
        chk("midrst_busy_any_byp", busy_any1, 1'b0);
        chk("midrst_wb_err_byp", wb_err1, 1'b0);
        m_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        apply(mk(1, 5, 1, 12, 1, 1, 5, 0, 0, 0, 0, 0), 1'b1);

        // Model-checked random traffic on a few registers to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom_range(0, 15) == 0), 1'b0, 1'b0);
            apply(v, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
